// File: rtl/common_pkg.sv
// Shared types for the systolic array datapath.
//   SYS_ARRAY_SIZE : largest number of lanes any array instance may have
//   data_t         : one operand element as it travels through the array
package common_pkg;
  localparam int SYS_ARRAY_SIZE = 4;
  localparam int DATA_W         = 8;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/feed_array_if.sv
// Row handshake between the operand memory path and feed_array.
//   row_valid_i : a row is offered on row_data_i
//   row_data_i  : one full matrix row, lane 0 = element 0
//   row_last_i  : the offered row closes the matrix (qualified by row_valid_i)
//   row_ready_o : feed_array takes a row this cycle
//
// Handshake: a row transfers on a rising clock edge where row_valid_i and
// row_ready_o are both high. While row_valid_i is high and row_ready_o is low
// the master holds row_data_i and row_last_i stable. row_ready_o never
// depends on row_valid_i, so the master may wait for ready before raising valid.
// Signal suffixes are seen from feed_array, which owns the slave modport.
interface feed_array_if #(
  parameter int SIZE = common_pkg::SYS_ARRAY_SIZE
);
  logic                              row_valid_i;
  common_pkg::data_t [SIZE-1:0]      row_data_i;
  logic                              row_last_i;
  logic                              row_ready_o;

  modport master (
    output row_valid_i,
    output row_data_i,
    output row_last_i,
    input  row_ready_o
  );

  modport slave (
    input  row_valid_i,
    input  row_data_i,
    input  row_last_i,
    output row_ready_o
  );
endinterface

// File: rtl/feed_array.sv
// feed_array: turns one full matrix row per handshake into a diagonal
// wavefront for the systolic array. Lane k is delayed by k extra cycles so
// element k of a row reaches the array k cycles after element 0. done_o pulses
// when the last row's final element (lane SIZE-1) is on array_data_o.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous, active-high reset
//   en_i           array advance enable; 0 freezes every register
//   row_if         feed_array_if.slave row handshake (valid/ready/data/last)
//   array_data_o   skewed lane data into the array
//   array_valid_o  per-lane element valid
//   busy_o         FSM is not IDLE
//   done_o         one-cycle pulse aligned with the last element on lane SIZE-1
//   dbg_state_o    current FSM state (IDLE=0, STREAM=1, FLUSH=2)
//
// Build option FEED_ZERO_FILL_EN: when defined, bubbles carry data 0 so that
// array_data_o is 0 whenever its valid is 0. When undefined, bubbles only
// clear valid and lane data keeps its previous value.
module feed_array #(
  parameter int SIZE = common_pkg::SYS_ARRAY_SIZE
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  feed_array_if.slave                  row_if,
  output common_pkg::data_t [SIZE-1:0] array_data_o,
  output logic [SIZE-1:0]              array_valid_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   dbg_state_o
);
  import common_pkg::*;

  localparam int CW = $clog2(SIZE) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          accept;

  // Ready depends only on enable and registered state, never on valid.
  assign row_if.row_ready_o = en_i && (state_q != ST_FLUSH);
  assign accept             = row_if.row_valid_i && row_if.row_ready_o;

  // ---------------------------------------------------------------------------
  // Skew delay lines: lane k has k+1 stages; the output is the last stage.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic [k:0] vld_q;
    data_t      dat_q [k+1];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_q <= '0;
        for (int s = 0; s <= k; s++) begin
          dat_q[s] <= '0;
        end
      end else if (en_i) begin
        vld_q[0] <= accept;
        if (accept) begin
          dat_q[0] <= row_if.row_data_i[k];
        end
`ifdef FEED_ZERO_FILL_EN
        else begin
          dat_q[0] <= '0;
        end
`endif
        for (int s = 1; s <= k; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign array_valid_o[k] = vld_q[k];
    assign array_data_o[k]  = dat_q[k];
  end

  // ---------------------------------------------------------------------------
  // Control FSM. FLUSH counts down the SIZE-1 cycles the last row needs to
  // reach lane SIZE-1 after it entered lane 0, so done lines up with it.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;   // held while en_i is low
    if (en_i) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE, ST_STREAM: begin
          if (accept) begin
            if (row_if.row_last_i) begin
              if (SIZE == 1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_FLUSH;
                cnt_d   = CW'(SIZE - 1);
              end
            end else begin
              state_d = ST_STREAM;
            end
          end
        end
        ST_FLUSH: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_feed_array.sv
// Directed bench for feed_array: a table of per-cycle {inputs, expected
// outputs} for a 4-lane instance, plus hand sequences for reset and a
// 1-lane instance.
module tb_feed_array;
  import common_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;
  logic rst1, en1;

  feed_array_if #(.SIZE(4)) rif ();
  data_t [3:0] array_data;
  logic  [3:0] array_valid;
  logic        busy, done;
  logic  [1:0] dbg_state;

  feed_array #(.SIZE(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .row_if       (rif.slave),
    .array_data_o (array_data),
    .array_valid_o(array_valid),
    .busy_o       (busy),
    .done_o       (done),
    .dbg_state_o  (dbg_state)
  );

  feed_array_if #(.SIZE(1)) rif1 ();
  data_t [0:0] array_data1;
  logic  [0:0] array_valid1;
  logic        busy1, done1;
  logic  [1:0] dbg_state1;

  feed_array #(.SIZE(1)) dut1 (
    .clk_i        (clk),
    .rst_i        (rst1),
    .en_i         (en1),
    .row_if       (rif1.slave),
    .array_data_o (array_data1),
    .array_valid_o(array_valid1),
    .busy_o       (busy1),
    .done_o       (done1),
    .dbg_state_o  (dbg_state1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected data of a bubble that follows an element with value held.
  function automatic logic [7:0] bub(input logic [7:0] held);
`ifdef FEED_ZERO_FILL_EN
    return 8'h00;
`else
    return held;
`endif
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        en;
    logic        vld;
    logic        lst;
    logic [31:0] d;
    logic        rdy;
    logic [3:0]  ev;
    logic        bsy;
    logic        dn;
    logic [3:0]  chk;   // lanes whose data is compared
    logic [31:0] ed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input logic l, input logic [31:0] d,
                              input logic rdy, input logic [3:0] ev,
                              input logic bsy, input logic dn,
                              input logic [3:0] chk, input logic [31:0] ed);
    vec_t x;
    x.rst = r; x.en = e; x.vld = v; x.lst = l; x.d = d;
    x.rdy = rdy; x.ev = ev; x.bsy = bsy; x.dn = dn; x.chk = chk; x.ed = ed;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // single row with last
    vecs.push_back(mk(0,1,1,1,32'h04030201, 1,4'b0000,0,0,4'b0000,32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0001,1,0,4'b0001,32'h00000001));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0010,1,0,4'b0010,32'h00000200));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0100,1,0,4'b0100,32'h00030000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b1000,0,1,4'b1000,32'h04000000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b0000,0,0,4'b0000,32'h0));
    // three back-to-back rows
    vecs.push_back(mk(0,1,1,0,32'h04030201, 1,4'b0000,0,0,4'b0000,32'h0));
    vecs.push_back(mk(0,1,1,0,32'h08070605, 1,4'b0001,1,0,4'b0001,32'h00000001));
    vecs.push_back(mk(0,1,1,1,32'h0c0b0a09, 1,4'b0011,1,0,4'b0011,32'h00000205));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0111,1,0,4'b0111,32'h00030609));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b1110,1,0,4'b1110,32'h04070a00));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b1100,1,0,4'b1100,32'h080b0000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b1000,0,1,4'b1000,32'h0c000000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b0000,0,0,4'b0000,32'h0));
    // gap between rows
    vecs.push_back(mk(0,1,1,0,32'h24232221, 1,4'b0000,0,0,4'b0000,32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b0001,1,0,4'b0001,32'h00000021));
    vecs.push_back(mk(0,1,1,1,32'h34333231, 1,4'b0010,1,0,4'b0011,{16'h0, 8'h22, bub(8'h21)}));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0101,1,0,4'b0111,{8'h0, 8'h23, bub(8'h22), 8'h31}));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b1010,1,0,4'b1110,{8'h24, bub(8'h23), 8'h32, 8'h0}));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0100,1,0,4'b1100,{bub(8'h24), 8'h33, 16'h0}));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b1000,0,1,4'b1000,32'h34000000));
    // enable low for two cycles mid-FLUSH
    vecs.push_back(mk(0,1,1,1,32'h44434241, 1,4'b0000,0,0,4'b0000,32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0001,1,0,4'b0001,32'h00000041));
    vecs.push_back(mk(0,0,0,0,32'h0,        0,4'b0010,1,0,4'b0010,32'h00004200));
    vecs.push_back(mk(0,0,0,0,32'h0,        0,4'b0010,1,0,4'b0010,32'h00004200));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0010,1,0,4'b0010,32'h00004200));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0100,1,0,4'b0100,32'h00430000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b1000,0,1,4'b1000,32'h44000000));
    // enable low on the done cycle: done holds until the next enabled edge
    vecs.push_back(mk(0,1,1,1,32'h48474645, 1,4'b0000,0,0,4'b0000,32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0001,1,0,4'b0001,32'h00000045));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0010,1,0,4'b0010,32'h00004600));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0100,1,0,4'b0100,32'h00470000));
    vecs.push_back(mk(0,0,0,0,32'h0,        0,4'b1000,0,1,4'b1000,32'h48000000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b1000,0,1,4'b1000,32'h48000000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b0000,0,0,4'b0000,32'h0));
    // reset in STREAM with two rows in flight, then a fresh row
    vecs.push_back(mk(0,1,1,0,32'h54535251, 1,4'b0000,0,0,4'b0000,32'h0));
    vecs.push_back(mk(0,1,1,0,32'h64636261, 1,4'b0001,1,0,4'b0001,32'h00000051));
    vecs.push_back(mk(1,1,0,0,32'h0,        1,4'b0011,1,0,4'b0011,32'h00005261));
    vecs.push_back(mk(0,1,1,1,32'h74737271, 1,4'b0000,0,0,4'b1111,32'h0));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0001,1,0,4'b1111,32'h00000071));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0010,1,0,4'b0010,32'h00007200));
    vecs.push_back(mk(0,1,0,0,32'h0,        0,4'b0100,1,0,4'b0100,32'h00730000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b1000,0,1,4'b1000,32'h74000000));
    vecs.push_back(mk(0,1,0,0,32'h0,        1,4'b0000,0,0,4'b0000,32'h0));

    // ---------------- reset state ----------------
    rst = 1'b1; en = 1'b1;
    rif.row_valid_i = 1'b0; rif.row_last_i = 1'b0; rif.row_data_i = '0;
    rst1 = 1'b1; en1 = 1'b1;
    rif1.row_valid_i = 1'b0; rif1.row_last_i = 1'b0; rif1.row_data_i = '0;
    step();
    step();
    check("rst_data",  -1, 32'(array_data),  32'h0);
    check("rst_valid", -1, 32'(array_valid), 32'h0);
    check("rst_busy",  -1, 32'(busy),        32'h0);
    check("rst_done",  -1, 32'(done),        32'h0);
    rst = 1'b0; rst1 = 1'b0;
    step();
    check("rst_ready_en1", -1, 32'(rif.row_ready_o), 32'h1);
    en = 1'b0;
    #1;
    check("rst_ready_en0", -1, 32'(rif.row_ready_o), 32'h0);
    en = 1'b1;
    step();

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      rst             = vecs[i].rst;
      en              = vecs[i].en;
      rif.row_valid_i = vecs[i].vld;
      rif.row_last_i  = vecs[i].lst;
      for (int l = 0; l < 4; l++) rif.row_data_i[l] = vecs[i].d[l*8 +: 8];
      #1;
      check("ready", i, 32'(rif.row_ready_o), 32'(vecs[i].rdy));
      check("valid", i, 32'(array_valid),     32'(vecs[i].ev));
      check("busy",  i, 32'(busy),            32'(vecs[i].bsy));
      check("done",  i, 32'(done),            32'(vecs[i].dn));
      for (int l = 0; l < 4; l++) begin
        if (vecs[i].chk[l]) check($sformatf("data_l%0d", l), i,
                                  32'(array_data[l]), 32'(vecs[i].ed[l*8 +: 8]));
      end
      step();
    end
    rst = 1'b0; en = 1'b1;
    rif.row_valid_i = 1'b0; rif.row_last_i = 1'b0;

    // ---------------- SIZE=1 instance ----------------
    check("s1_idle_valid", -1, 32'(array_valid1), 32'h0);
    rif1.row_valid_i = 1'b1; rif1.row_last_i = 1'b1; rif1.row_data_i[0] = 8'h07;
    #1;
    check("s1_ready", -1, 32'(rif1.row_ready_o), 32'h1);
    step();
    rif1.row_valid_i = 1'b0; rif1.row_last_i = 1'b0;
    #1;
    check("s1_data",  -1, 32'(array_data1[0]), 32'h7);
    check("s1_valid", -1, 32'(array_valid1),   32'h1);
    check("s1_done",  -1, 32'(done1),          32'h1);
    check("s1_busy",  -1, 32'(busy1),          32'h0);
    check("s1_ready_after", -1, 32'(rif1.row_ready_o), 32'h1);
    step();
    check("s1_valid_end", -1, 32'(array_valid1), 32'h0);
    check("s1_done_end",  -1, 32'(done1),        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
